// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - button debounce, run-state FSM and step/direction/load sequencer for the 6-bit display counter
module counter_seq_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 2
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic       btn_run_n,
    input  logic       btn_dir_n,
    input  logic       btn_load_n,
    input  logic       mode_bounce,
    input  logic [5:0] preload,
    input  logic [5:0] cnt_value,
    output logic       cnt_load,
    output logic [5:0] cnt_load_val,
    output logic       cnt_step,
    output logic       cnt_dir,
    output logic [1:0] state_show
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_TERM = PS_W'(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LOAD  = 2'b11
    } state_t;

    // Button lanes: bit 0 = run, bit 1 = dir, bit 2 = load (all active-low raw)
    logic [2:0]      btn_raw;
    logic [2:0]      sync_a;
    logic [2:0]      sync_b;
    logic [2:0]      db_level;
    logic [2:0]      db_prev;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    logic            press_run;
    logic            press_dir;
    logic            press_load;

    state_t          state;
    logic [PS_W-1:0] prescaler;
    logic [5:0]      limit;

    logic            tick;
    logic            stay_run;
    logic            step_ok;
    logic            flip;

    assign btn_raw    = {btn_load_n, btn_dir_n, btn_run_n};
    assign press_run  = press[0];
    assign press_dir  = press[1];
    assign press_load = press[2];
    assign state_show = state;

    // Synchronise, debounce and edge-detect each button; a press is one cycle after the debounced fall
    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            sync_a   <= '1;
            sync_b   <= '1;
            db_level <= '1;
            db_prev  <= '1;
            press    <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a  <= btn_raw;
            sync_b  <= sync_a;
            db_prev <= db_level;
            press   <= db_prev & ~db_level;
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] != db_level[i]) begin
                    if (db_cnt[i] == DB_MAX) begin
                        db_level[i] <= sync_b[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Tick decode plus step/bounce qualification; steps only when the FSM stays in RUN
    always_comb begin
        tick     = 1'b0;
        stay_run = 1'b0;
        step_ok  = 1'b0;
        flip     = 1'b0;
        tick     = (state == S_RUN) && (prescaler == PS_TERM);
        stay_run = tick && !press_load && !press_run;
        step_ok  = stay_run && !(mode_bounce && (limit == 6'd0));
        flip     = stay_run && mode_bounce && (limit != 6'd0) &&
                   ((cnt_dir && (cnt_value >= limit)) || (!cnt_dir && (cnt_value == 6'd0)));
    end

    // Run-state FSM with registered load/step/direction outputs and the step prescaler
    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt_load     <= 1'b0;
            cnt_load_val <= 6'd0;
            cnt_step     <= 1'b0;
            cnt_dir      <= 1'b1;
            limit        <= 6'd0;
            prescaler    <= '0;
        end else begin
            cnt_load <= 1'b0;
            cnt_step <= step_ok;
            // A manual toggle and a bounce reversal in the same cycle invert only once
            cnt_dir  <= cnt_dir ^ (press_dir | flip);

            if (state != S_RUN || tick) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PS_W'(1);
            end

            case (state)
                S_IDLE, S_PAUSE: begin
                    if (press_load) begin
                        state        <= S_LOAD;
                        cnt_load     <= 1'b1;
                        cnt_load_val <= preload;
                        limit        <= preload;
                    end else if (press_run) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (press_load) begin
                        state        <= S_LOAD;
                        cnt_load     <= 1'b1;
                        cnt_load_val <= preload;
                        limit        <= preload;
                    end else if (press_run) begin
                        state <= S_PAUSE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - scoreboard testbench for counter_seq_ctrl with a counter datapath model
module tb_counter_seq_ctrl;

    logic       clk_50MHz = 1'b0;
    logic       rst_n;
    logic       btn_run_n;
    logic       btn_dir_n;
    logic       btn_load_n;
    logic       mode_bounce;
    logic [5:0] preload;
    logic [5:0] cnt_value;
    logic       cnt_load;
    logic [5:0] cnt_load_val;
    logic       cnt_step;
    logic       cnt_dir;
    logic [1:0] state_show;

    always #10 clk_50MHz = ~clk_50MHz;

    counter_seq_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV(2)
    ) dut (
        .clk_50MHz(clk_50MHz),
        .rst_n(rst_n),
        .btn_run_n(btn_run_n),
        .btn_dir_n(btn_dir_n),
        .btn_load_n(btn_load_n),
        .mode_bounce(mode_bounce),
        .preload(preload),
        .cnt_value(cnt_value),
        .cnt_load(cnt_load),
        .cnt_load_val(cnt_load_val),
        .cnt_step(cnt_step),
        .cnt_dir(cnt_dir),
        .state_show(state_show)
    );

    // Counter datapath model fed back as cnt_value
    logic [5:0] model_cnt = 6'd0;
    logic       model_clr;
    assign cnt_value = model_cnt;

    always @(posedge clk_50MHz) begin
        if (model_clr) model_cnt <= 6'd0;
        else if (cnt_load) model_cnt <= cnt_load_val;
        else if (cnt_step) model_cnt <= cnt_dir ? model_cnt + 6'd1 : model_cnt - 6'd1;
    end

    typedef struct {
        logic       dir;
        logic [5:0] val;
    } step_t;

    typedef struct {
        string      name;
        int         kind;
        logic [1:0] st;
        logic       dir;
        logic       stp;
        logic       ld;
        logic [5:0] val;
    } probe_t;

    step_t      exp_step[$];
    logic [5:0] exp_load[$];
    probe_t     probes[$];

    int errors = 0;
    int checks = 0;
    int t      = 0;

    int bdir[16] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    int bval[16] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1, 2, 3};

    task automatic go(input int k);
        while (t < k) begin
            @(negedge clk_50MHz);
            t++;
        end
    endtask

    task automatic probe(input string name, input int kind, input logic [1:0] st,
                         input logic dir, input logic stp, input logic ld, input logic [5:0] val);
        probe_t p;
        p.name = name; p.kind = kind; p.st = st; p.dir = dir; p.stp = stp; p.ld = ld; p.val = val;
        probes.push_back(p);
    endtask

    task automatic push_step(input logic dir, input logic [5:0] val);
        step_t s;
        s.dir = dir;
        s.val = val;
        exp_step.push_back(s);
    endtask

    task automatic do_probe(input probe_t p);
        logic ok;
        checks++;
        case (p.kind)
            0: ok = (state_show === p.st);
            1: ok = (state_show === p.st) && (cnt_dir === p.dir);
            2: ok = (state_show === p.st) && (cnt_dir === p.dir) && (cnt_step === p.stp) &&
                    (cnt_load === p.ld) && (cnt_load_val === p.val);
            3: ok = (cnt_load_val === p.val);
            default: ok = (exp_step.size() == 0) && (exp_load.size() == 0);
        endcase
        if (!ok) begin
            errors++;
            $display("FAIL %s: got state=%b dir=%b step=%b load=%b val=%0d pend_steps=%0d pend_loads=%0d, required state=%b dir=%b step=%b load=%b val=%0d (kind %0d)",
                     p.name, state_show, cnt_dir, cnt_step, cnt_load, cnt_load_val,
                     exp_step.size(), exp_load.size(), p.st, p.dir, p.stp, p.ld, p.val, p.kind);
        end
    endtask

    // Monitor: compares strobes against the scoreboard and services probes, just after each edge
    initial begin
        step_t      s;
        logic [5:0] lv;
        forever begin
            @(posedge clk_50MHz);
            #1;
            if (cnt_step && cnt_load) begin
                checks++;
                errors++;
                $display("FAIL step_load_overlap: got step=1 load=1, required not both");
            end
            if (cnt_step) begin
                checks++;
                if (exp_step.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step: got step dir=%b value=%0d state=%b, required no step",
                             cnt_dir, cnt_value, state_show);
                end else begin
                    s = exp_step.pop_front();
                    if (cnt_dir !== s.dir || cnt_value !== s.val) begin
                        errors++;
                        $display("FAIL step: got dir=%b value=%0d, required dir=%b value=%0d",
                                 cnt_dir, cnt_value, s.dir, s.val);
                    end
                end
            end
            if (cnt_load) begin
                checks++;
                if (exp_load.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_load: got load val=%0d, required no load", cnt_load_val);
                end else begin
                    lv = exp_load.pop_front();
                    if (cnt_load_val !== lv) begin
                        errors++;
                        $display("FAIL load_val: got %0d, required %0d", cnt_load_val, lv);
                    end
                end
            end
            while (probes.size() > 0) do_probe(probes.pop_front());
        end
    end

    // Stimulus: directed scenarios; t counts negedges from each scenario start
    initial begin
        rst_n = 1'b0; btn_run_n = 1'b1; btn_dir_n = 1'b1; btn_load_n = 1'b1;
        mode_bounce = 1'b0; preload = 6'd0; model_clr = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        probe("reset", 2, 2'b00, 1'b1, 1'b0, 1'b0, 6'd0);
        @(negedge clk_50MHz);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50MHz);

        // Short load glitches: no event
        t = 0;
        for (int r = 0; r < 5; r++) begin
            go(r * 8);     btn_load_n = 1'b0;
            go(r * 8 + 3); btn_load_n = 1'b1;
        end
        go(50); probe("glitch_idle", 2, 2'b00, 1'b1, 1'b0, 1'b0, 6'd0);
        go(60);

        // Clean load of 5 from IDLE
        t = 0; preload = 6'd5; exp_load.push_back(6'd5); btn_load_n = 1'b0;
        go(6);  probe("load_pre", 0, 2'b00, 1'b1, 1'b0, 1'b0, 6'd0);
        go(7);  probe("load_cycle", 2, 2'b11, 1'b1, 1'b0, 1'b1, 6'd5);
        go(8);  probe("load_done", 2, 2'b00, 1'b1, 1'b0, 1'b0, 6'd5); preload = 6'd9;
        go(12); btn_load_n = 1'b1;
        go(14); probe("load_hold", 3, 2'b00, 1'b1, 1'b0, 1'b0, 6'd5);
        go(25);

        // Run: 8 up-steps every 3 cycles, then pause
        t = 0;
        for (int k = 0; k < 8; k++) push_step(1'b1, 6'(5 + k));
        btn_run_n = 1'b0;
        go(6);  probe("run_pre", 0, 2'b00, 1'b1, 1'b0, 1'b0, 6'd0);
        go(7);  probe("run_enter", 1, 2'b01, 1'b1, 1'b0, 1'b0, 6'd0);
        go(12); btn_run_n = 1'b1;
        go(25); btn_run_n = 1'b0;
        go(31); probe("run_still", 0, 2'b01, 1'b1, 1'b0, 1'b0, 6'd0);
        go(32); probe("pause", 0, 2'b10, 1'b1, 1'b0, 1'b0, 6'd0);
        go(37); btn_run_n = 1'b1;
        go(40); probe("run_steps_done", 4, 2'b00, 1'b0, 1'b0, 1'b0, 6'd0);
        go(55);

        // Load limit 3 from PAUSE, clear counter, enable bounce
        t = 0; preload = 6'd3; exp_load.push_back(6'd3); btn_load_n = 1'b0;
        go(7);  probe("bload_cycle", 0, 2'b11, 1'b1, 1'b0, 1'b0, 6'd0);
        go(8);  probe("bload_idle", 0, 2'b00, 1'b1, 1'b0, 1'b0, 6'd0);
        go(9);  model_clr = 1'b1;
        go(10); model_clr = 1'b0; mode_bounce = 1'b1;
        go(12); btn_load_n = 1'b1;
        go(25);

        // Bounce run; dir press lands on the limit flip; run+load together ends in LOAD
        t = 0;
        for (int k = 0; k < 16; k++) push_step(bdir[k][0], 6'(bval[k]));
        btn_run_n = 1'b0;
        go(7);  probe("bounce_enter", 0, 2'b01, 1'b1, 1'b0, 1'b0, 6'd0);
        go(12); btn_run_n = 1'b1;
        go(30); btn_dir_n = 1'b0;
        go(42); btn_dir_n = 1'b1;
        go(50); btn_run_n = 1'b0; btn_load_n = 1'b0; exp_load.push_back(6'd3);
        go(56); probe("bounce_last", 1, 2'b01, 1'b0, 1'b0, 1'b0, 6'd0);
        go(57); probe("runload_load", 0, 2'b11, 1'b0, 1'b0, 1'b0, 6'd0);
        go(58); probe("runload_idle", 1, 2'b00, 1'b0, 1'b0, 1'b0, 6'd0);
        go(62); btn_run_n = 1'b1; btn_load_n = 1'b1;
        go(64); probe("bounce_done", 4, 2'b00, 1'b0, 1'b0, 1'b0, 6'd0); mode_bounce = 1'b0;
        go(75);

        // Reset mid-RUN with cnt_dir=0
        t = 0; push_step(1'b0, 6'd3); btn_run_n = 1'b0;
        go(7);  probe("rr_enter", 1, 2'b01, 1'b0, 1'b0, 1'b0, 6'd0);
        go(11); probe("rr_before", 1, 2'b01, 1'b0, 1'b0, 1'b0, 6'd0);
        go(12); rst_n = 1'b0; btn_run_n = 1'b1;
        probe("reset_mid_run", 2, 2'b00, 1'b1, 1'b0, 1'b0, 6'd0);
        go(13); rst_n = 1'b1;
        go(15); probe("final_empty", 4, 2'b00, 1'b0, 1'b0, 1'b0, 6'd0);
        go(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
